// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared AXI4 encodings, FSM state types and LFSR helper
// Purpose: burst/response encodings, the only supported transfer size, the
//          read/write FSM state enums and the jitter LFSR step function.
// Ports:   none (package).
package axi4_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   // Only full 32-bit beats are served; any other size is a slave error.
   localparam logic [2:0] SIZE_4B = 3'b010;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_DATA = 2'd2
   } r_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_WAIT = 2'd2,
      W_RESP = 2'd3
   } w_state_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Fibonacci LFSR, taps 16,14,13,11 (bit 16 is lfsr[15]).
   function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

endpackage

// File: rtl/sram_1r1w.sv
// rtl/sram_1r1w.sv - word-organised SRAM, async read, byte-masked sync write
// Purpose: backing store for the AXI4 responder. A read and a write to the
//          same word in one cycle returns the old contents (the write only
//          lands at the clock edge).
// Ports:   clock; raddr/rdata combinational read port;
//          we/waddr/wdata/wbe synchronous write port with byte enables.
//          Contents are never reset.
module sram_1r1w
   import axi4_pkg::*;
#(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [3:0]    wbe
);

   logic [31:0] mem [DEPTH];

   assign rdata = mem[raddr];

   always_ff @(posedge clock) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wbe[b]) begin
               mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/axi4_sram_responder.sv
// rtl/axi4_sram_responder.sv - AXI4 slave answering IFU/LSU traffic from an SRAM
// Purpose: single-outstanding AXI4 slave with independent read and write
//          FSMs, fixed READ_LAT/WRITE_LAT latency, INCR/FIXED bursts, byte
//          strobes and DECERR/SLVERR responses.
// Ports:   clock, reset (synchronous, active-high);
//          AW: awvalid/awready/awaddr/awid/awlen/awsize/awburst
//          W : wvalid/wready/wdata/wstrb/wlast
//          B : bvalid/bready/bresp/bid
//          AR: arvalid/arready/araddr/arid/arlen/arsize/arburst
//          R : rvalid/rready/rdata/rresp/rlast/rid
// Option:  AXI_SLV_RAND_DELAY_EN adds 0..7 LFSR-driven extra latency cycles
//          per burst and single-cycle rvalid gaps between read beats.
module axi4_sram_responder
   import axi4_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter int          DEPTH_WORDS = 4096,
   parameter int          READ_LAT    = 1,
   parameter int          WRITE_LAT   = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] awaddr,
   input  logic [3:0]  awid,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic [1:0]  awburst,
   input  logic        wvalid,
   output logic        wready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   output logic        bvalid,
   input  logic        bready,
   output logic [1:0]  bresp,
   output logic [3:0]  bid,
   input  logic        arvalid,
   output logic        arready,
   input  logic [31:0] araddr,
   input  logic [3:0]  arid,
   input  logic [7:0]  arlen,
   input  logic [2:0]  arsize,
   input  logic [1:0]  arburst,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic [3:0]  rid
);

   localparam int          IDX_W  = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN   = 33'(4 * DEPTH_WORDS);
   localparam logic [4:0]  R_LOAD = 5'(READ_LAT - 1);
   localparam logic [4:0]  W_LOAD = 5'(WRITE_LAT - 1);

   // 33-bit subtraction: addresses below BASE_ADDR borrow into bit 32 and
   // therefore compare as larger than SPAN.
   function automatic logic in_range(input logic [31:0] a);
      return ({1'b0, a} - {1'b0, BASE_ADDR}) < SPAN;
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
      return IDX_W'((a - BASE_ADDR) >> 2);
   endfunction

   // ------------------------------------------------------------------
   // Latency jitter source
   // ------------------------------------------------------------------
   logic [4:0] extra_lat;
   logic       gap_req;

`ifdef AXI_SLV_RAND_DELAY_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb lfsr_d = lfsr16_next(lfsr_q);

   always_ff @(posedge clock) begin
      if (reset) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_d;
   end

   assign extra_lat = {2'b00, lfsr_q[2:0]};
   assign gap_req   = lfsr_q[3];
`else
   assign extra_lat = 5'd0;
   assign gap_req   = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Read channel state
   // ------------------------------------------------------------------
   r_state_e    r_state_q, r_state_d;
   logic [31:0] r_addr_q, r_addr_d;
   logic [3:0]  r_id_q, r_id_d;
   logic [7:0]  r_len_q, r_len_d;
   logic [7:0]  r_beat_q, r_beat_d;
   logic        r_incr_q, r_incr_d;
   logic        r_err_q, r_err_d;        // size/burst error for whole burst
   logic        r_wrap_q, r_wrap_d;      // address ran past 32'hFFFF_FFFF
   logic [4:0]  r_lat_q, r_lat_d;
   logic        r_gap_q, r_gap_d;
   logic        r_hold_vld_q, r_hold_vld_d;
   logic [31:0] r_hold_q, r_hold_d;

   logic [32:0] r_next;
   logic [4:0]  r_load;
   logic [1:0]  r_resp;
   logic [31:0] r_word;
   logic [31:0] sram_rdata;

   always_comb begin
      r_state_d    = r_state_q;
      r_addr_d     = r_addr_q;
      r_id_d       = r_id_q;
      r_len_d      = r_len_q;
      r_beat_d     = r_beat_q;
      r_incr_d     = r_incr_q;
      r_err_d      = r_err_q;
      r_wrap_d     = r_wrap_q;
      r_lat_d      = r_lat_q;
      r_gap_d      = r_gap_q;
      r_hold_vld_d = r_hold_vld_q;
      r_hold_d     = r_hold_q;
      r_next       = {1'b0, r_addr_q} + 33'd4;
      r_load       = R_LOAD + extra_lat;

      arready = (r_state_q == R_IDLE);
      rvalid  = (r_state_q == R_DATA) && !r_gap_q;

      if (r_wrap_q || !in_range(r_addr_q)) r_resp = RESP_DECERR;
      else if (r_err_q)                    r_resp = RESP_SLVERR;
      else                                 r_resp = RESP_OKAY;

      // Once a beat has been shown and stalled, replay the captured word so
      // a concurrent write to the same location cannot change it mid-stall.
      if (r_hold_vld_q)               r_word = r_hold_q;
      else if (r_resp == RESP_OKAY)   r_word = sram_rdata;
      else                            r_word = 32'd0;

      rdata = 32'd0;
      rresp = RESP_OKAY;
      if (rvalid) begin
         rdata = r_word;
         rresp = r_resp;
      end
      rlast = rvalid && (r_beat_q == r_len_q);
      rid   = r_id_q;

      case (r_state_q)
         R_IDLE: begin
            if (arvalid) begin
               r_addr_d     = araddr;
               r_id_d       = arid;
               r_len_d      = arlen;
               r_beat_d     = 8'd0;
               r_incr_d     = (arburst == BURST_INCR);
               r_err_d      = (arsize != SIZE_4B) || (arburst == BURST_WRAP);
               r_wrap_d     = 1'b0;
               r_gap_d      = 1'b0;
               r_hold_vld_d = 1'b0;
               r_lat_d      = r_load;
               r_state_d    = (r_load == 5'd0) ? R_DATA : R_WAIT;
            end
         end
         R_WAIT: begin
            r_lat_d = r_lat_q - 5'd1;
            if (r_lat_q == 5'd1) r_state_d = R_DATA;
         end
         R_DATA: begin
            r_gap_d = 1'b0;
            if (rvalid && rready) begin
               r_hold_vld_d = 1'b0;
               if (r_beat_q == r_len_q) begin
                  r_state_d = R_IDLE;
               end else begin
                  r_beat_d = r_beat_q + 8'd1;
                  r_gap_d  = gap_req;
                  if (r_incr_q) begin
                     r_addr_d = r_next[31:0];
                     r_wrap_d = r_wrap_q | r_next[32];
                  end
               end
            end else if (rvalid) begin
               r_hold_vld_d = 1'b1;
               r_hold_d     = r_word;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state_q    <= R_IDLE;
         r_addr_q     <= 32'd0;
         r_id_q       <= 4'd0;
         r_len_q      <= 8'd0;
         r_beat_q     <= 8'd0;
         r_incr_q     <= 1'b0;
         r_err_q      <= 1'b0;
         r_wrap_q     <= 1'b0;
         r_lat_q      <= 5'd0;
         r_gap_q      <= 1'b0;
         r_hold_vld_q <= 1'b0;
         r_hold_q     <= 32'd0;
      end else begin
         r_state_q    <= r_state_d;
         r_addr_q     <= r_addr_d;
         r_id_q       <= r_id_d;
         r_len_q      <= r_len_d;
         r_beat_q     <= r_beat_d;
         r_incr_q     <= r_incr_d;
         r_err_q      <= r_err_d;
         r_wrap_q     <= r_wrap_d;
         r_lat_q      <= r_lat_d;
         r_gap_q      <= r_gap_d;
         r_hold_vld_q <= r_hold_vld_d;
         r_hold_q     <= r_hold_d;
      end
   end

   // ------------------------------------------------------------------
   // Write channel state
   // ------------------------------------------------------------------
   w_state_e    w_state_q, w_state_d;
   logic [31:0] w_addr_q, w_addr_d;
   logic [3:0]  w_id_q, w_id_d;
   logic [7:0]  w_len_q, w_len_d;
   logic [7:0]  w_beat_q, w_beat_d;
   logic        w_incr_q, w_incr_d;
   logic        w_err_q, w_err_d;        // size/burst error: suppress writes
   logic        w_wrap_q, w_wrap_d;
   logic        w_dec_q, w_dec_d;
   logic        w_slv_q, w_slv_d;
   logic [4:0]  w_lat_q, w_lat_d;

   logic [32:0] w_next;
   logic [4:0]  w_load;
   logic        w_ok;
   logic        w_last;
   logic        sram_we;

   always_comb begin
      w_state_d = w_state_q;
      w_addr_d  = w_addr_q;
      w_id_d    = w_id_q;
      w_len_d   = w_len_q;
      w_beat_d  = w_beat_q;
      w_incr_d  = w_incr_q;
      w_err_d   = w_err_q;
      w_wrap_d  = w_wrap_q;
      w_dec_d   = w_dec_q;
      w_slv_d   = w_slv_q;
      w_lat_d   = w_lat_q;
      w_next    = {1'b0, w_addr_q} + 33'd4;
      w_load    = W_LOAD + extra_lat;
      w_ok      = in_range(w_addr_q) && !w_wrap_q;
      w_last    = (w_beat_q == w_len_q);
      sram_we   = 1'b0;

      awready = (w_state_q == W_IDLE);
      wready  = (w_state_q == W_DATA);
      bvalid  = (w_state_q == W_RESP);
      bid     = w_id_q;
      bresp   = RESP_OKAY;
      if (bvalid) begin
         if (w_dec_q)      bresp = RESP_DECERR;
         else if (w_slv_q) bresp = RESP_SLVERR;
      end

      case (w_state_q)
         W_IDLE: begin
            if (awvalid) begin
               w_addr_d  = awaddr;
               w_id_d    = awid;
               w_len_d   = awlen;
               w_beat_d  = 8'd0;
               w_incr_d  = (awburst == BURST_INCR);
               w_err_d   = (awsize != SIZE_4B) || (awburst == BURST_WRAP);
               w_slv_d   = (awsize != SIZE_4B) || (awburst == BURST_WRAP);
               w_wrap_d  = 1'b0;
               w_dec_d   = 1'b0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (wvalid) begin
               sram_we = w_ok && !w_err_q;
               if (!w_ok)           w_dec_d = 1'b1;
               // wlast early or missing: stop here and flag the burst.
               if (wlast != w_last) w_slv_d = 1'b1;
               if (wlast || w_last) begin
                  w_lat_d   = w_load;
                  w_state_d = (w_load == 5'd0) ? W_RESP : W_WAIT;
               end else begin
                  w_beat_d = w_beat_q + 8'd1;
                  if (w_incr_q) begin
                     w_addr_d = w_next[31:0];
                     w_wrap_d = w_wrap_q | w_next[32];
                  end
               end
            end
         end
         W_WAIT: begin
            w_lat_d = w_lat_q - 5'd1;
            if (w_lat_q == 5'd1) w_state_d = W_RESP;
         end
         W_RESP: begin
            if (bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         w_state_q <= W_IDLE;
         w_addr_q  <= 32'd0;
         w_id_q    <= 4'd0;
         w_len_q   <= 8'd0;
         w_beat_q  <= 8'd0;
         w_incr_q  <= 1'b0;
         w_err_q   <= 1'b0;
         w_wrap_q  <= 1'b0;
         w_dec_q   <= 1'b0;
         w_slv_q   <= 1'b0;
         w_lat_q   <= 5'd0;
      end else begin
         w_state_q <= w_state_d;
         w_addr_q  <= w_addr_d;
         w_id_q    <= w_id_d;
         w_len_q   <= w_len_d;
         w_beat_q  <= w_beat_d;
         w_incr_q  <= w_incr_d;
         w_err_q   <= w_err_d;
         w_wrap_q  <= w_wrap_d;
         w_dec_q   <= w_dec_d;
         w_slv_q   <= w_slv_d;
         w_lat_q   <= w_lat_d;
      end
   end

   // ------------------------------------------------------------------
   // Backing store
   // ------------------------------------------------------------------
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] w_idx;

   assign r_idx = word_idx(r_addr_q);
   assign w_idx = word_idx(w_addr_q);

   sram_1r1w #(
      .DEPTH (DEPTH_WORDS),
      .AW    (IDX_W)
   ) u_sram (
      .clock (clock),
      .raddr (r_idx),
      .rdata (sram_rdata),
      .we    (sram_we),
      .waddr (w_idx),
      .wdata (wdata),
      .wbe   (wstrb)
   );

endmodule

// File: doc/axi4_sram_responder.md
Name: axi4_sram_responder

Overview:
- AXI4 slave backed by a word-addressed on-chip SRAM model.
- Answers instruction fetches from the IFU read master and load/store traffic from the LSU.
- Independent read and write channel FSMs, configurable read latency, INCR/FIXED bursts, byte strobes, error responses.
- Sits behind the crossbar as the default memory responder in simulation and FPGA builds.

Parameters:
- BASE_ADDR, 32'h3000_0000, first byte address decoded by this slave.
- DEPTH_WORDS, 4096, number of 32-bit words; valid range is BASE_ADDR .. BASE_ADDR+4*DEPTH_WORDS-1.
- READ_LAT, 1, cycles from AR handshake to first rvalid; allowed range 1..15.
- WRITE_LAT, 1, cycles from wlast handshake to bvalid; allowed range 1..15.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- awvalid in 1 / awready out 1 / awaddr in 32 / awid in 4 / awlen in 8 / awsize in 3 / awburst in 2  write address channel
- wvalid in 1 / wready out 1 / wdata in 32 / wstrb in 4 / wlast in 1  write data channel
- bvalid out 1 / bready in 1 / bresp out 2 / bid out 4  write response channel
- arvalid in 1 / arready out 1 / araddr in 32 / arid in 4 / arlen in 8 / arsize in 3 / arburst in 2  read address channel
- rvalid out 1 / rready in 1 / rdata out 32 / rresp out 2 / rlast out 1 / rid out 4  read data channel

Behaviour:
- Interface decision: reset is reset, synchronous, active-high; clock is clock.
- Reset values: arready=1, awready=1, wready=0, rvalid=0, rlast=0, rdata=0, rresp=0, rid=0, bvalid=0, bresp=0, bid=0. SRAM contents are not reset.
- Read FSM states: R_IDLE, R_WAIT, R_DATA.
  - arready=1 only in R_IDLE.
  - AR handshake in cycle T latches addr, id, len, burst, size; moves to R_WAIT; latency counter = READ_LAT-1.
  - R_WAIT goes to R_DATA when the counter reaches 0, so rvalid is first high in cycle T+READ_LAT.
  - R_DATA holds rdata/rresp/rlast/rid stable while rvalid && !rready.
  - On each beat handshake: INCR advances the address by 4; FIXED keeps it. The beat count runs 0..len. rlast=1 on beat len.
  - After the last beat: back to R_IDLE; arready is high the next cycle. No back-to-back AR overlap.
- Read errors:
  - Beat address out of range: rresp=2'b11 (DECERR), rdata=0.
  - arsize!=3'b010 or arburst=WRAP (2'b10): every beat rresp=2'b10 (SLVERR), rdata=0.
  - The burst still completes all len+1 beats.
  - Address wrap past 32'hFFFF_FFFF is out of range and gets DECERR.
- Write FSM states: W_IDLE, W_DATA, W_WAIT, W_RESP.
  - awready=1 only in W_IDLE; wready=1 only in W_DATA.
  - Each W beat writes bytes where wstrb[i]=1, but only if the address is in range and there is no size/burst error.
  - wlast asserted before beat awlen, or missing on beat awlen: the burst terminates at wlast (or at beat awlen) and the error is recorded as SLVERR.
  - After the terminating beat: W_WAIT for WRITE_LAT-1 cycles, then W_RESP with bvalid=1 held until bready.
  - bresp priority: DECERR over SLVERR over OKAY. bid = awid.
- Simultaneous read and write to the same word in the same cycle: the read beat returns the old data (read-before-write).
- A read beat presented one cycle after the write handshake sees the new data.
- Reset asserted mid-burst aborts both FSMs to IDLE with the reset output values. Partially written data remains in the SRAM.

Optional Feature:
- Macro: AXI_SLV_RAND_DELAY_EN.
- When defined: a 16-bit Fibonacci LFSR (seed 16'hACE1, taps 16,14,13,11) runs freely. Each AR/AW handshake loads the latency counter with READ_LAT-1 (or WRITE_LAT-1) plus lfsr[2:0], i.e. 0..7 extra cycles. While in R_DATA, rvalid is deasserted for one cycle whenever lfsr[3]=1 between beats. This stresses IFU/LSU stall handling.
- When undefined: latency is exactly as specified and beats stream without gaps.

Decomposition:
- Shared package axi4_pkg: burst encodings FIXED/INCR/WRAP, resp encodings OKAY/EXOKAY/SLVERR/DECERR, SIZE_4B=3'b010, and the FSM state enums.
- One sub-module, sram_1r1w (DEPTH_WORDS x 32): combinational read port, byte-masked synchronous write port.

Test Plan:
- Reset, then AR araddr=32'h3000_0000, arlen=0, READ_LAT=1 → rvalid in cycle T+1 with rlast=1, rresp=0, rid=arid, and data preloaded at word 0.
- AW 32'h3000_0010, len=3, INCR, data 1,2,3,4 with wstrb=4'hF, then INCR read len=3 → 1,2,3,4 with rlast only on beat 3, and bresp=OKAY.
- rready held low 5 cycles mid-burst → rdata, rresp and rlast stay stable; no beat is skipped or duplicated.
- Write wstrb=4'b0101, wdata=32'hAABBCCDD over 32'h11223344 → read back 32'h11BB33DD.
- araddr=32'h2000_0000 → rresp=DECERR, rdata=0. arsize=3'b001 → SLVERR. AW with wlast on beat 1 of len=3 → bresp=SLVERR.
- Reset pulsed during R_DATA beat 2 of 4 → next cycle rvalid=0 and arready=1; a fresh AR is accepted normally.
